// File: rtl/method_initiator_08_if.sv
// ----------------------------------------------------------------------------
// method_initiator_08_if
//   Bundles the host request/response stream and the core's start/result/check
//   method ports used by method_initiator_08.
//   master : the initiator (drives req_ready, start_*, EN_*, rsp_*, busy)
//   slave  : the environment (host + core) on the other side
//   Signals:
//     req_valid/req_ready/req_a/req_b      host request stream
//     start_a/start_b/EN_start/RDY_start   core start(a,b) method
//     resresult/RDY_result                 core result method
//     EN_check/chresult/RDY_check          core check action/value
//     rsp_valid/rsp_ready/rsp_result/
//     rsp_check/rsp_timeout                host response stream
//     busy                                 initiator has work pending
// ----------------------------------------------------------------------------
interface method_initiator_08_if #(
    parameter int WIDTH = 12
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] start_a;
    logic [WIDTH-1:0] start_b;
    logic             EN_start;
    logic             RDY_start;
    logic [WIDTH-1:0] resresult;
    logic             RDY_result;
    logic             EN_check;
    logic [WIDTH-1:0] chresult;
    logic             RDY_check;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [WIDTH-1:0] rsp_check;
    logic             rsp_timeout;
    logic             busy;

    modport master (
        input  req_valid, req_a, req_b, RDY_start, resresult, RDY_result,
               chresult, RDY_check, rsp_ready,
        output req_ready, start_a, start_b, EN_start, EN_check,
               rsp_valid, rsp_result, rsp_check, rsp_timeout, busy
    );

    modport slave (
        output req_valid, req_a, req_b, RDY_start, resresult, RDY_result,
               chresult, RDY_check, rsp_ready,
        input  req_ready, start_a, start_b, EN_start, EN_check,
               rsp_valid, rsp_result, rsp_check, rsp_timeout, busy
    );
endinterface

// File: rtl/method_initiator_08.sv
// ----------------------------------------------------------------------------
// method_initiator_08
//   Initiator for a start/result/check method core. Host operand pairs are
//   queued, issued one at a time with start(a,b), the result is captured, the
//   check action fires and its value is captured, and both are returned to
//   the host. Only one transaction is in flight at a time.
//
//   Ports:
//     CLK    clock, all state on the rising edge
//     RST_N  asynchronous active-low reset
//     bus    method_initiator_08_if.master (host stream + core methods)
//
//   Parameters:
//     WIDTH          operand/result/check width
//     FIFO_DEPTH     request queue depth (power of 2, >= 2)
//     TIMEOUT_CYCLES wait limit in WAIT_RES/CHECK (timeout build only)
//
//   Optional feature macro: INIT_TIMEOUT_EN
//     defined   : a 16-bit wait counter forces a response with rsp_timeout=1
//                 and zeroed data once it reaches TIMEOUT_CYCLES
//     undefined : the FSM waits forever and rsp_timeout is tied 0
// ----------------------------------------------------------------------------
module method_initiator_08 #(
    parameter int WIDTH          = 12,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    method_initiator_08_if.master   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit wait counter");
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        WAIT_RES = 2'd1,
        CHECK    = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t         state, state_nx;
    logic           rst_done;

    // ---------------- request queue ----------------
    req_t           mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           empty, push, pop;

    logic           en_start, en_check;
    logic           cap_res, cap_chk, tmo_fire, tmo_hit;
    logic [WIDTH-1:0] res_q, chk_q;

    assign empty         = (count == '0);
    // req_ready stays low until the first clock after reset release
    assign bus.req_ready = rst_done && (count != FULL_CNT);
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = en_start;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= '{a: bus.req_a, b: bus.req_b};
    end

    assign bus.start_a = empty ? '0 : mem[rd_ptr].a;
    assign bus.start_b = empty ? '0 : mem[rd_ptr].b;

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ISSUE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        en_start = 1'b0;
        en_check = 1'b0;
        cap_res  = 1'b0;
        cap_chk  = 1'b0;
        tmo_fire = 1'b0;
        case (state)
            ISSUE: begin
                en_start = !empty && bus.RDY_start;
                if (!empty && bus.RDY_start) state_nx = WAIT_RES;
            end
            WAIT_RES: begin
                // a real result wins over a simultaneous timeout
                if (bus.RDY_result) begin
                    cap_res  = 1'b1;
                    state_nx = CHECK;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_nx = RESP;
                end
            end
            CHECK: begin
                en_check = bus.RDY_check;
                if (bus.RDY_check) begin
                    cap_chk  = 1'b1;
                    state_nx = RESP;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nx = ISSUE;
            end
            default: state_nx = ISSUE;
        endcase
    end

    assign bus.EN_start = en_start;
    assign bus.EN_check = en_check;

    // ---------------- capture registers ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_q <= '0;
            chk_q <= '0;
        end else if (cap_res) begin
            res_q <= bus.resresult;
        end else if (cap_chk) begin
            chk_q <= bus.chresult;
        end else if (tmo_fire) begin
            res_q <= '0;
            chk_q <= '0;
        end
    end

`ifdef INIT_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        to_q;

    // Cleared on every state change, so it restarts on entry to WAIT_RES
    // and again on entry to CHECK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
        end else if (state_nx != state) begin
            tmo_cnt <= '0;
        end else if ((state == WAIT_RES) || (state == CHECK)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_q <= 1'b0;
        end else if (cap_res) begin
            to_q <= 1'b0;
        end else if (tmo_fire) begin
            to_q <= 1'b1;
        end
    end

    assign bus.rsp_timeout = (state == RESP) && to_q;
`else
    assign tmo_hit         = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    // ---------------- host response ----------------
    assign bus.rsp_valid  = (state == RESP);
    // data is masked outside RESP so the response bus reads 0 when idle
    assign bus.rsp_result = (state == RESP) ? res_q : '0;
    assign bus.rsp_check  = (state == RESP) ? chk_q : '0;
    assign bus.busy       = (state != ISSUE) || !empty;

endmodule

// File: tb/tb_method_initiator_08.sv
module tb_method_initiator_08;
    localparam int W  = 12;
    localparam int D  = 4;
    localparam int TO = 255;
`ifdef INIT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    method_initiator_08_if #(.WIDTH(W)) bus();

    method_initiator_08 #(.WIDTH(W), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transaction progress: 0 idle, 1 awaiting result, 2 awaiting check, 3 responding
    typedef struct packed {logic [W-1:0] a; logic [W-1:0] b;} pair_t;
    pair_t        mq[$];
    bit           m_rd;
    int           m_ph;
    logic [W-1:0] m_res, m_chk;
    bit           m_to;
    int           m_tc;

    int           n_en_start = 0, n_en_check = 0, n_rsp = 0, n_bad_en = 0;
    logic [W-1:0] start_log[$];

    always @(negedge CLK) begin : mon
        bit e_rr, e_es, e_ec, e_rv, e_busy, e_to, push;
        logic [W-1:0] e_sa, e_sb, e_res, e_chk;
        pair_t np;
        if (!RST_N) begin
            mq.delete();
            m_rd = 0; m_ph = 0; m_res = '0; m_chk = '0; m_to = 0; m_tc = 0;
        end
        e_rr   = m_rd && (mq.size() < D);
        e_es   = (m_ph == 0) && (mq.size() > 0) && bus.RDY_start;
        e_sa   = (mq.size() > 0) ? mq[0].a : '0;
        e_sb   = (mq.size() > 0) ? mq[0].b : '0;
        e_ec   = (m_ph == 2) && bus.RDY_check;
        e_rv   = (m_ph == 3);
        e_res  = e_rv ? m_res : '0;
        e_chk  = e_rv ? m_chk : '0;
        e_to   = e_rv && m_to;
        e_busy = (m_ph != 0) || (mq.size() > 0);

        chk("req_ready",   32'(bus.req_ready),   32'(e_rr));
        chk("EN_start",    32'(bus.EN_start),    32'(e_es));
        chk("start_a",     32'(bus.start_a),     32'(e_sa));
        chk("start_b",     32'(bus.start_b),     32'(e_sb));
        chk("EN_check",    32'(bus.EN_check),    32'(e_ec));
        chk("rsp_valid",   32'(bus.rsp_valid),   32'(e_rv));
        chk("rsp_result",  32'(bus.rsp_result),  32'(e_res));
        chk("rsp_check",   32'(bus.rsp_check),   32'(e_chk));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e_to));
        chk("busy",        32'(bus.busy),        32'(e_busy));

        if (bus.EN_start === 1'b1) begin n_en_start++; start_log.push_back(bus.start_a); end
        if (bus.EN_check === 1'b1) n_en_check++;
        if ((bus.rsp_valid === 1'b1) && bus.rsp_ready) n_rsp++;
        if ((bus.EN_start === 1'b1 && !bus.RDY_start) ||
            (bus.EN_check === 1'b1 && !bus.RDY_check)) n_bad_en++;

        if (RST_N) begin
            push = bus.req_valid && e_rr;
            np   = {bus.req_a, bus.req_b};
            case (m_ph)
                0: if (e_es) begin m_ph = 1; m_tc = 0; end
                1: begin
                    if (bus.RDY_result) begin
                        m_res = bus.resresult; m_to = 0; m_ph = 2; m_tc = 0;
                    end else if (TMO_EN && m_tc == TO) begin
                        m_ph = 3; m_to = 1; m_res = '0; m_chk = '0;
                    end else m_tc++;
                end
                2: begin
                    if (e_ec) begin
                        m_chk = bus.chresult; m_ph = 3;
                    end else if (TMO_EN && m_tc == TO) begin
                        m_ph = 3; m_to = 1; m_res = '0; m_chk = '0;
                    end else m_tc++;
                end
                default: if (bus.rsp_ready) m_ph = 0;
            endcase
            if (e_es) void'(mq.pop_front());
            if (push) mq.push_back(np);
            m_rd = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic set_rdy(bit s, bit r, bit c, bit rr);
        bus.RDY_start = s; bus.RDY_result = r; bus.RDY_check = c; bus.rsp_ready = rr;
    endtask

    initial begin : stim
        int k, first, snap_c, snap_r, snap_s;
        bit seen, tmo_seen;
        logic [W-1:0] held;
        bus.req_valid = 0; bus.req_a = '0; bus.req_b = '0;
        bus.resresult = '0; bus.chresult = '0;
        set_rdy(0, 0, 0, 0);

        // reset state
        step(); @(negedge CLK);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        step(); RST_N = 1; @(negedge CLK);
        chk("rel_req_ready_c0", 32'(bus.req_ready), 0);
        step(); @(negedge CLK);
        chk("rel_req_ready_c1", 32'(bus.req_ready), 1);

        // 1: basic latency
        step();
        set_rdy(1, 1, 1, 1);
        bus.resresult = 12'hABC; bus.chresult = 12'h001;
        bus.req_valid = 1; bus.req_a = 12'h123; bus.req_b = 12'h456;
        step(); bus.req_valid = 0; @(negedge CLK);
        chk("t1_en_start_c1", 32'(bus.EN_start), 1);
        chk("t1_start_a", 32'(bus.start_a), 32'h123);
        chk("t1_start_b", 32'(bus.start_b), 32'h456);
        step(); @(negedge CLK);
        chk("t1_en_check_c2", 32'(bus.EN_check), 0);
        step(); @(negedge CLK);
        chk("t1_en_check_c3", 32'(bus.EN_check), 1);
        step(); @(negedge CLK);
        chk("t1_rsp_valid_c4", 32'(bus.rsp_valid), 1);
        chk("t1_rsp_result", 32'(bus.rsp_result), 32'hABC);
        chk("t1_rsp_check", 32'(bus.rsp_check), 32'h001);
        step(); @(negedge CLK);
        chk("t1_idle_busy", 32'(bus.busy), 0);

        // 2: fill queue while start is blocked, then drain in order
        start_log.delete();
        set_rdy(0, 1, 1, 1);
        bus.resresult = 12'h5A5; bus.chresult = 12'h3C3;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            bus.req_valid = 1; bus.req_a = 12'h200 + 12'(k); bus.req_b = 12'h300 + 12'(k);
            @(negedge CLK);
            if (bus.req_ready) k++;
        end
        chk("t2_accepted_full", 32'(k), 4);
        chk("t2_req_ready_full", 32'(bus.req_ready), 0);
        bus.RDY_start = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            bus.req_valid = (k < 5);
            bus.req_a = 12'h200 + 12'(k); bus.req_b = 12'h300 + 12'(k);
            @(negedge CLK);
            if (bus.req_valid && bus.req_ready) k++;
        end
        bus.req_valid = 0;
        chk("t2_issued", 32'(start_log.size()), 5);
        for (int i = 0; i < 5; i++)
            if (i < start_log.size()) chk("t2_order", 32'(start_log[i]), 32'h200 + 32'(i));

        // 3: response held off by the host
        set_rdy(1, 1, 1, 0);
        step(); bus.req_valid = 1; bus.req_a = 12'h0AA; bus.req_b = 12'h0BB;
        step(); bus.req_a = 12'h0CC; bus.req_b = 12'h0DD;
        step(); bus.req_valid = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(); @(negedge CLK);
            seen = bus.rsp_valid;
        end
        chk("t3_rsp_seen", 32'(seen), 1);
        held = bus.rsp_result;
        for (int i = 0; i < 10; i++) begin
            step(); @(negedge CLK);
            chk("t3_hold_valid", 32'(bus.rsp_valid), 1);
            chk("t3_hold_result", 32'(bus.rsp_result), 32'(held));
            chk("t3_hold_no_start", 32'(bus.EN_start), 0);
        end
        step(); bus.rsp_ready = 1; @(negedge CLK);
        step(); @(negedge CLK);
        chk("t3_start_after_hs", 32'(bus.EN_start), 1);
        chk("t3_start_a_next", 32'(bus.start_a), 32'h0CC);
        repeat (10) step();

        // 4: result never ready
        set_rdy(1, 0, 1, 1);
        step(); bus.req_valid = 1; bus.req_a = 12'h777; bus.req_b = 12'h888;
        first = -1; tmo_seen = 0;
        for (int i = 1; i <= 300; i++) begin
            step(); bus.req_valid = 0; @(negedge CLK);
            if (bus.rsp_valid && first < 0) begin first = i; tmo_seen = bus.rsp_timeout; end
        end
`ifdef INIT_TIMEOUT_EN
        chk("t4_timeout_cycle", 32'(first), 258);
        chk("t4_timeout_flag", 32'(tmo_seen), 1);
`else
        chk("t4_no_response", 32'(first), 32'hFFFF_FFFF);
`endif
        bus.RDY_result = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(); @(negedge CLK);
            if (bus.rsp_valid) seen = 1;
        end
        chk("t4_late_rsp", 32'(seen), 32'(!TMO_EN));

        // 5: reset while in CHECK with two requests queued
        set_rdy(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(); bus.req_valid = 1; bus.req_a = 12'h400 + 12'(i); bus.req_b = 12'h500;
        end
        step(); bus.req_valid = 0; @(negedge CLK);
        chk("t5_in_check_busy", 32'(bus.busy), 1);
        chk("t5_in_check_no_rsp", 32'(bus.rsp_valid), 0);
        step(); RST_N = 0; bus.RDY_check = 1; #1;
        chk("t5_rst_busy", 32'(bus.busy), 0);
        chk("t5_rst_en_check", 32'(bus.EN_check), 0);
        chk("t5_rst_req_ready", 32'(bus.req_ready), 0);
        chk("t5_rst_start_a", 32'(bus.start_a), 0);
        step(); RST_N = 1; @(negedge CLK);
        chk("t5_rel_req_ready_c0", 32'(bus.req_ready), 0);
        snap_r = n_rsp; snap_s = n_en_start;
        step(); @(negedge CLK);
        chk("t5_rel_req_ready_c1", 32'(bus.req_ready), 1);
        repeat (10) step();
        chk("t5_no_stale_rsp", 32'(n_rsp - snap_r), 0);
        chk("t5_no_stale_start", 32'(n_en_start - snap_s), 0);

        // 6: check ready toggling
        set_rdy(1, 1, 0, 1);
        snap_c = n_en_check; snap_r = n_rsp;
        step(); bus.req_valid = 1; bus.req_a = 12'h0F0; bus.req_b = 12'h00F;
        bus.chresult = 12'h6E6;
        for (int i = 0; i < 14; i++) begin
            step(); bus.req_valid = 0; bus.RDY_check = i[0];
        end
        chk("t6_one_en_check", 32'(n_en_check - snap_c), 1);
        chk("t6_one_rsp", 32'(n_rsp - snap_r), 1);

        // randomized traffic
        snap_r = n_rsp;
        for (int i = 0; i < 3000; i++) begin
            step();
            bus.req_valid  = ($urandom_range(0, 1) == 1);
            bus.req_a      = W'($urandom);
            bus.req_b      = W'($urandom);
            bus.RDY_start  = ($urandom_range(0, 3) != 0);
            bus.RDY_result = ($urandom_range(0, 3) != 0);
            bus.RDY_check  = ($urandom_range(0, 1) == 1);
            bus.rsp_ready  = ($urandom_range(0, 2) != 0);
            bus.resresult  = W'($urandom);
            bus.chresult   = W'($urandom);
            RST_N          = ($urandom_range(0, 499) != 0);
        end
        step(); RST_N = 1;
        repeat (5) step();
        chk("rand_rsp_progress", 32'(n_rsp - snap_r > 100), 1);
        chk("en_only_with_rdy", 32'(n_bad_en), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
